// File: rtl/bus_target_pkg.sv
// Shared definitions for the 8-bit multiplexed external bus.
// The bus_state encodings are common to the initiator and the target.
package bus_target_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [1:0] {
    BUS_ADDR_LOW   = 2'b00,
    BUS_ADDR_HIGH  = 2'b01,
    BUS_DATA_READ  = 2'b10,
    BUS_DATA_WRITE = 2'b11
  } bus_state_e;

  // Device address as captured from the two address phases
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } bus_addr_t;

endpackage

// File: rtl/bus_target_if.sv
// Pin-side bundle of the multiplexed bus: four-phase req/ack, phase code,
// data in both directions, space select.
interface bus_target_if;
  import bus_target_pkg::*;

  logic              req;
  logic              ack;
  bus_state_e        state;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              output_enable;
  logic              io;

  modport master (
    output req, state, data_in, io,
    input  ack, data_out, output_enable
  );

  modport slave (
    input  req, state, data_in, io,
    output ack, data_out, output_enable
  );

endinterface

// File: rtl/bus_target.sv
// Responder end of the multiplexed bus: turns each data phase into one
// device strobe and stalls ack until the device reports ready.
module bus_target
  import bus_target_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  bus_target_if.slave       bus,
  output logic              dev_read,
  output logic              dev_write,
  output logic [ADDR_W-1:0] dev_addr,
  output logic              dev_io,
  output logic [DATA_W-1:0] dev_wdata,
  input  logic [DATA_W-1:0] dev_rdata,
  input  logic              dev_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DEV  = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [1:0]        fsm_q,   fsm_d;
  logic              ack_q,   ack_d;
  logic              oe_q,    oe_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              read_q,  read_d;
  logic              write_q, write_d;
  bus_addr_t         addr_q,  addr_d;
  logic              io_q,    io_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      ack_q   <= 1'b0;
      oe_q    <= 1'b0;
      rdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      io_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      ack_q   <= ack_d;
      oe_q    <= oe_d;
      rdata_q <= rdata_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      io_q    <= io_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and next-output logic; every register holds by default
  always_comb begin
    fsm_d   = fsm_q;
    ack_d   = ack_q;
    oe_d    = oe_q;
    rdata_d = rdata_q;
    read_d  = read_q;
    write_d = write_q;
    addr_d  = addr_q;
    io_d    = io_q;
    wdata_d = wdata_q;

    case (fsm_q)
      IDLE: begin
        if (bus.req) begin
          case (bus.state)
            BUS_ADDR_LOW: begin
              addr_d.lo = bus.data_in;
              ack_d     = 1'b1;
              fsm_d     = ACK;
            end
            BUS_ADDR_HIGH: begin
              addr_d.hi = bus.data_in;
              ack_d     = 1'b1;
              fsm_d     = ACK;
            end
            BUS_DATA_READ: begin
              io_d   = bus.io;
              read_d = 1'b1;
              fsm_d  = DEV;
            end
            BUS_DATA_WRITE: begin
              io_d    = bus.io;
              wdata_d = bus.data_in;
              write_d = 1'b1;
              fsm_d   = DEV;
            end
            default: ;
          endcase
        end
      end

      // Completes even if req has been withdrawn; ACK then clears it next cycle
      DEV: begin
        if (dev_ready) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          ack_d   = 1'b1;
          fsm_d   = ACK;
          if (read_q) begin
            rdata_d = dev_rdata;
            oe_d    = 1'b1;
          end
        end
      end

      ACK: begin
        if (!bus.req) begin
          ack_d = 1'b0;
          oe_d  = 1'b0;
          fsm_d = IDLE;
        end
      end

      default: fsm_d = IDLE;
    endcase
  end

  assign bus.ack           = ack_q;
  assign bus.output_enable = oe_q;
  assign bus.data_out      = rdata_q;
  assign dev_read          = read_q;
  assign dev_write         = write_q;
  assign dev_addr          = addr_q;
  assign dev_io            = io_q;
  assign dev_wdata         = wdata_q;

endmodule

// File: tb/tb_bus_target.sv
// Directed bench for bus_target: the bench plays the initiator and a device
// with a programmable wait count; read data is checked through a scoreboard.
module tb_bus_target;
  import bus_target_pkg::*;

  logic        clk;
  logic        rst;
  logic        dev_read;
  logic        dev_write;
  logic [15:0] dev_addr;
  logic        dev_io;
  logic [7:0]  dev_wdata;
  logic [7:0]  dev_rdata;
  logic        dev_ready;

  bus_target_if bif ();

  bus_target dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif.slave),
    .dev_read  (dev_read),
    .dev_write (dev_write),
    .dev_addr  (dev_addr),
    .dev_io    (dev_io),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata),
    .dev_ready (dev_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int oe_without_ack = 0;
  int drive_conflict = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] model_addr;

  // Behavioural device: ready after dev_wait strobe cycles
  int dev_wait = 0;
  int dev_cnt  = 0;
  logic [7:0] dev_val = 8'h00;
  always @(posedge clk) begin
    if (rst || !(dev_read || dev_write)) dev_cnt <= 0;
    else dev_cnt <= dev_cnt + 1;
  end
  assign dev_ready = (dev_read || dev_write) && (dev_cnt >= dev_wait);
  assign dev_rdata = dev_val;

  // Pin-level monitors
  always @(negedge clk) begin
    if (bif.output_enable && !bif.ack) oe_without_ack++;
    if (bif.output_enable && bif.req && bif.state != BUS_DATA_READ) drive_conflict++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete four-phase transaction driven and checked from the initiator side
  task automatic xfer(input bus_state_e st, input logic [7:0] d, input logic io, input int w);
    int lat;
    int strobes;
    bit is_data;
    bit is_read;
    logic [7:0] exp;
    is_data = (st == BUS_DATA_READ) || (st == BUS_DATA_WRITE);
    is_read = (st == BUS_DATA_READ);
    dev_wait = w;
    @(negedge clk);
    bif.req = 1'b1;
    bif.state = st;
    bif.data_in = d;
    bif.io = io;
    if (st == BUS_ADDR_LOW)  model_addr[7:0]  = d;
    if (st == BUS_ADDR_HIGH) model_addr[15:8] = d;
    if (is_read) exp_q.push_back(dev_val);
    lat = 0;
    strobes = 0;
    do begin
      @(negedge clk);
      lat++;
      if (dev_read || dev_write) strobes++;
      if (is_data && lat == 1) begin
        check("dev_addr", 32'(dev_addr), 32'(model_addr));
        check("dev_io", 32'(dev_io), 32'(io));
        check("dev_read", 32'(dev_read), 32'(is_read));
        check("dev_write", 32'(dev_write), 32'(!is_read));
        if (!is_read) check("dev_wdata", 32'(dev_wdata), 32'(d));
      end
    end while (!bif.ack && lat < 40);
    check("ack_latency", 32'(lat), is_data ? 32'(w + 2) : 32'd1);
    check("strobe_cycles", 32'(strobes), is_data ? 32'(w + 1) : 32'd0);
    check("oe_at_ack", 32'(bif.output_enable), 32'(is_read));
    if (is_read) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check("read_data", 32'(bif.data_out), 32'(exp));
    end
    bif.req = 1'b0;
    @(negedge clk);
    check("ack_fall", 32'(bif.ack), 32'd0);
    check("oe_fall", 32'(bif.output_enable), 32'd0);
  endtask

  initial begin
    int lat;
    bif.req = 1'b0;
    bif.state = BUS_ADDR_LOW;
    bif.data_in = 8'h00;
    bif.io = 1'b0;
    model_addr = 16'h0000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(bif.ack), 32'd0);
    check("rst_oe", 32'(bif.output_enable), 32'd0);
    check("rst_strobes", 32'({dev_read, dev_write}), 32'd0);
    check("rst_regs", {dev_addr, dev_wdata, bif.data_out}, 32'd0);
    check("rst_io", 32'(dev_io), 32'd0);
    rst = 1'b0;

    // Memory read 0x12AB, zero-wait device
    dev_val = 8'h5A;
    xfer(BUS_ADDR_LOW, 8'hAB, 1'b0, 0);
    xfer(BUS_ADDR_HIGH, 8'h12, 1'b0, 0);
    xfer(BUS_DATA_READ, 8'h00, 1'b0, 0);
    check("data_hold", 32'(bif.data_out), 32'h5A);

    // I/O write 0xC3 to port 0x0040, three wait cycles
    xfer(BUS_ADDR_LOW, 8'h40, 1'b1, 0);
    xfer(BUS_ADDR_HIGH, 8'h00, 1'b1, 0);
    xfer(BUS_DATA_WRITE, 8'hC3, 1'b1, 3);

    // Reset while a read sits in DEV
    xfer(BUS_ADDR_LOW, 8'h34, 1'b0, 0);
    xfer(BUS_ADDR_HIGH, 8'h12, 1'b0, 0);
    dev_wait = 5;
    @(negedge clk);
    bif.req = 1'b1;
    bif.state = BUS_DATA_READ;
    bif.io = 1'b1;
    @(negedge clk);
    check("pre_rst_read", 32'(dev_read), 32'd1);
    rst = 1'b1;
    bif.req = 1'b0;
    @(negedge clk);
    check("midrst_read", 32'(dev_read), 32'd0);
    check("midrst_ack", 32'(bif.ack), 32'd0);
    check("midrst_oe", 32'(bif.output_enable), 32'd0);
    check("midrst_regs", {dev_addr, dev_wdata, bif.data_out}, 32'd0);
    check("midrst_io", 32'(dev_io), 32'd0);
    rst = 1'b0;
    model_addr = 16'h0000;
    dev_val = 8'h3C;
    xfer(BUS_DATA_READ, 8'h00, 1'b0, 1);

    // Back-to-back: read 0xFFFF then write 0x00 to 0x0000
    dev_val = 8'h77;
    xfer(BUS_ADDR_LOW, 8'hFF, 1'b0, 0);
    xfer(BUS_ADDR_HIGH, 8'hFF, 1'b0, 0);
    xfer(BUS_DATA_READ, 8'h00, 1'b0, 2);
    xfer(BUS_ADDR_LOW, 8'h00, 1'b0, 0);
    xfer(BUS_ADDR_HIGH, 8'h00, 1'b0, 0);
    xfer(BUS_DATA_WRITE, 8'h00, 1'b0, 0);

    // req withdrawn while the device access is pending
    dev_wait = 3;
    dev_val = 8'hE1;
    @(negedge clk);
    bif.req = 1'b1;
    bif.state = BUS_DATA_READ;
    bif.io = 1'b0;
    @(negedge clk);
    check("viol_strobe", 32'(dev_read), 32'd1);
    bif.req = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bif.ack && lat < 40);
    check("viol_ack_seen", 32'(bif.ack), 32'd1);
    check("viol_data", 32'(bif.data_out), 32'hE1);
    @(negedge clk);
    check("viol_ack_drop", 32'(bif.ack), 32'd0);
    check("viol_oe_drop", 32'(bif.output_enable), 32'd0);
    dev_val = 8'h99;
    xfer(BUS_DATA_WRITE, 8'h5F, 1'b1, 0);
    xfer(BUS_DATA_READ, 8'h00, 1'b0, 0);

    check("oe_only_with_ack", 32'(oe_without_ack), 32'd0);
    check("no_drive_conflict", 32'(drive_conflict), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
